// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module  : load_store_unit_pkg
// Brief   : Load/store type codes, LSU state encoding and lane helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  localparam int LS_SEL_WIDTH = 3;

  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE = 4'd0;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB   = 4'd1;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH   = 4'd2;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW   = 4'd3;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU  = 4'd4;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU  = 4'd5;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB   = 4'd6;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH   = 4'd7;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW   = 4'd8;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_t;

  function automatic logic ls_is_store(input logic [LS_SEL_WIDTH:0] t);
    return (t == LS_TYPE_SB) || (t == LS_TYPE_SH) || (t == LS_TYPE_SW);
  endfunction

  function automatic logic ls_misaligned(input logic [LS_SEL_WIDTH:0] t,
                                         input logic [1:0] off);
    logic w_half;
    logic w_word;
    w_half = (t == LS_TYPE_LH) || (t == LS_TYPE_LHU) || (t == LS_TYPE_SH);
    w_word = (t == LS_TYPE_LW) || (t == LS_TYPE_SW);
    return (w_half && off[0]) || (w_word && (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// ============================================================================
// Module  : load_extend
// Brief   : Selects the addressed byte/half lane of a read word and extends it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [LS_SEL_WIDTH:0] i_ls_type,
  input  logic [1:0]            i_offset,
  input  logic [XLEN-1:0]       i_rdata,
  output logic [XLEN-1:0]       o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    o_data = '0;
    case (i_ls_type)
      LS_TYPE_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LS_TYPE_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      LS_TYPE_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LS_TYPE_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      LS_TYPE_LW:  o_data = i_rdata;
      default:     o_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : Word-bus load/store unit with lane steering and ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Valid,
  input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
  input  logic [XLEN-1:0]       i_Addr,
  input  logic [XLEN-1:0]       i_Write_Data,
  output logic                  o_Ready,
  output logic                  o_Done,
  output logic [XLEN-1:0]       o_Read_Data,
  output logic                  o_Misaligned,
  output logic                  o_Bus_Error,
  output logic                  o_Mem_Req,
  output logic                  o_Mem_We,
  output logic [XLEN-1:0]       o_Mem_Addr,
  output logic [3:0]            o_Mem_Wstrb,
  output logic [XLEN-1:0]       o_Mem_Wdata,
  input  logic                  i_Mem_Ack,
  input  logic [XLEN-1:0]       i_Mem_Rdata
);

  localparam logic [TIMEOUT_W-1:0] c_last_count = TIMEOUT_W'(TIMEOUT_CYC - 1);

  lsu_state_t              r_state;
  logic [LS_SEL_WIDTH:0]   r_type;
  logic [1:0]              r_offset;
  logic [TIMEOUT_W-1:0]    r_count;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_misaligned;
  logic                    r_bus_error;
  logic                    r_req;
  logic                    r_we;
  logic [XLEN-1:0]         r_addr;
  logic [3:0]              r_wstrb;
  logic [XLEN-1:0]         r_wdata;
  logic [XLEN-1:0]         r_rdata;

  logic                    w_accept;
  logic [3:0]              w_wstrb;
  logic [XLEN-1:0]         w_wdata;
  logic [XLEN-1:0]         w_load_data;

  assign w_accept = i_Valid && (i_Load_Store_Type != LS_TYPE_NONE);

  // Store lane steering; loads leave strobes and data at zero.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    case (i_Load_Store_Type)
      LS_TYPE_SB: begin
        w_wstrb = 4'b0001 << i_Addr[1:0];
        w_wdata = {(XLEN/8){i_Write_Data[7:0]}};
      end
      LS_TYPE_SH: begin
        w_wstrb = i_Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(XLEN/16){i_Write_Data[15:0]}};
      end
      LS_TYPE_SW: begin
        w_wstrb = 4'b1111;
        w_wdata = i_Write_Data;
      end
      default: ;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_ls_type (r_type),
    .i_offset  (r_offset),
    .i_rdata   (i_Mem_Rdata),
    .o_data    (w_load_data)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state      <= LSU_IDLE;
      r_type       <= LS_TYPE_NONE;
      r_offset     <= 2'b00;
      r_count      <= '0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wstrb      <= 4'b0000;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_type   <= i_Load_Store_Type;
            r_offset <= i_Addr[1:0];
            r_ready  <= 1'b0;
            r_count  <= '0;
            if (ls_misaligned(i_Load_Store_Type, i_Addr[1:0])) begin
              r_state      <= LSU_RESP;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
              r_rdata      <= '0;
            end else begin
              r_state <= LSU_ACCESS;
              r_req   <= 1'b1;
              r_we    <= ls_is_store(i_Load_Store_Type);
              r_addr  <= {i_Addr[XLEN-1:2], 2'b00};
              r_wstrb <= w_wstrb;
              r_wdata <= w_wdata;
            end
          end
        end
        LSU_ACCESS: begin
          // An ack in the final counted cycle still completes normally.
          if (i_Mem_Ack) begin
            r_state <= LSU_RESP;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_rdata <= w_load_data;
          end else if (r_count == c_last_count) begin
            r_state     <= LSU_RESP;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_done      <= 1'b1;
            r_bus_error <= 1'b1;
            r_rdata     <= '0;
            r_count     <= r_count + 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        LSU_RESP: begin
          r_state      <= LSU_IDLE;
          r_done       <= 1'b0;
          r_misaligned <= 1'b0;
          r_bus_error  <= 1'b0;
          r_ready      <= 1'b1;
        end
        default: begin
          r_state <= LSU_IDLE;
          r_ready <= 1'b1;
          r_req   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Ready      = r_ready;
  assign o_Done       = r_done;
  assign o_Read_Data  = r_rdata;
  assign o_Misaligned = r_misaligned;
  assign o_Bus_Error  = r_bus_error;
  assign o_Mem_Req    = r_req;
  assign o_Mem_We     = r_we;
  assign o_Mem_Addr   = r_addr;
  assign o_Mem_Wstrb  = r_wstrb;
  assign o_Mem_Wdata  = r_wdata;

endmodule

`default_nettype wire
